// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad entry sequencer for the alarm clock.
// Captures digits into a 4-digit HH:MM entry buffer, abandons a stalled entry
// after TIMEOUT_SECS seconds, validates the entry and issues one-cycle load
// strobes to the alarm register or the current-time counter.
//
// Ports:
//   clock, reset (async, active-low)
//   one_second     : one-cycle pulse per clock-second
//   key            : keypad code, 0-9 digit, 10..15 no key
//   alarm_button   : show alarm / commit entry as alarm time
//   time_button    : commit entry as current time
//   new_*_hr/min   : entry buffer digits
//   load_new_a/c   : one-cycle load strobes (alarm / time counter)
//   show_a         : display alarm time
//   show_new_time  : display entry buffer
//   entry_err      : one-cycle pulse on a rejected commit
//
// Optional feature: define KEYPAD_FULL_ENTRY_EN to reject commits made with
// fewer than four digits entered.
module keypad_entry_ctrl #(
   parameter logic [3:0]  NOKEY        = 4'd10,
   parameter int unsigned TIMEOUT_SECS = 10,
   parameter int unsigned CNT_W        = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       one_second,
   input  logic [3:0] key,
   input  logic       alarm_button,
   input  logic       time_button,
   output logic [3:0] new_ms_hr,
   output logic [3:0] new_ls_hr,
   output logic [3:0] new_ms_min,
   output logic [3:0] new_ls_min,
   output logic       load_new_a,
   output logic       load_new_c,
   output logic       show_a,
   output logic       show_new_time,
   output logic       entry_err
);

   typedef enum logic [2:0] {
      SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTERED,
      SHOW_ALARM, SET_ALARM_TIME, SET_CURRENT_TIME
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
   logic [3:0]       ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_a_q, load_a_d, load_c_q, load_c_d;
   logic             show_a_q, show_a_d, show_new_q, show_new_d;
   logic             err_q, err_d;

   logic is_digit_c, timeout_c, fmt_ok_c, entry_ok_c;

   // Any code at or above NOKEY counts as "no key".
   assign is_digit_c = (key < NOKEY);
   // The pulse that would bring the count to TIMEOUT_SECS ends the entry.
   assign timeout_c  = one_second && (cnt_q == CNT_W'(TIMEOUT_SECS - 1));

   // HH:MM range check: 00:00 .. 23:59.
   assign fmt_ok_c = (ms_hr_q <= 4'd2) &&
                     (ls_hr_q <= ((ms_hr_q == 4'd2) ? 4'd3 : 4'd9)) &&
                     (ms_min_q <= 4'd5) && (ls_min_q <= 4'd9);

`ifdef KEYPAD_FULL_ENTRY_EN
   logic [2:0] dcnt_q, dcnt_d;
   assign entry_ok_c = fmt_ok_c && (dcnt_q == 3'd4);
`else
   assign entry_ok_c = fmt_ok_c;
`endif

   // Next-state, buffer and registered-output logic.
   always_comb begin
      state_d  = state_q;
      ms_hr_d  = ms_hr_q;
      ls_hr_d  = ls_hr_q;
      ms_min_d = ms_min_q;
      ls_min_d = ls_min_q;
      cnt_d    = cnt_q;
`ifdef KEYPAD_FULL_ENTRY_EN
      dcnt_d   = dcnt_q;
`endif
      unique case (state_q)
         SHOW_TIME: begin
            cnt_d = '0;
            if (alarm_button)    state_d = SHOW_ALARM;
            else if (is_digit_c) state_d = KEY_STORED;
         end
         KEY_STORED: begin
            ms_hr_d  = ls_hr_q;
            ls_hr_d  = ms_min_q;
            ms_min_d = ls_min_q;
            ls_min_d = key;
            cnt_d    = '0;
`ifdef KEYPAD_FULL_ENTRY_EN
            if (dcnt_q != 3'd4) dcnt_d = dcnt_q + 3'd1;
`endif
            state_d  = KEY_WAITED;
         end
         KEY_WAITED, KEY_ENTERED: begin
            if (timeout_c) begin
               // Timeout beats any simultaneous key or button.
               ms_hr_d  = '0;
               ls_hr_d  = '0;
               ms_min_d = '0;
               ls_min_d = '0;
               cnt_d    = '0;
`ifdef KEYPAD_FULL_ENTRY_EN
               dcnt_d   = '0;
`endif
               state_d  = SHOW_TIME;
            end else begin
               if (one_second) cnt_d = cnt_q + CNT_W'(1);
               if (state_q == KEY_WAITED) begin
                  if (!is_digit_c) state_d = KEY_ENTERED;
               end else if (alarm_button) state_d = SET_ALARM_TIME;
               else if (time_button)      state_d = SET_CURRENT_TIME;
               else if (is_digit_c)       state_d = KEY_STORED;
            end
         end
         SHOW_ALARM: begin
            if (!alarm_button) state_d = SHOW_TIME;
         end
         SET_ALARM_TIME, SET_CURRENT_TIME: begin
            ms_hr_d  = '0;
            ls_hr_d  = '0;
            ms_min_d = '0;
            ls_min_d = '0;
`ifdef KEYPAD_FULL_ENTRY_EN
            dcnt_d   = '0;
`endif
            state_d  = SHOW_TIME;
         end
         default: state_d = SHOW_TIME;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      show_a_d   = (state_d == SHOW_ALARM);
      show_new_d = (state_d == KEY_STORED) || (state_d == KEY_WAITED) ||
                   (state_d == KEY_ENTERED);
      load_a_d   = (state_d == SET_ALARM_TIME) && entry_ok_c;
      load_c_d   = (state_d == SET_CURRENT_TIME) && entry_ok_c;
      err_d      = ((state_d == SET_ALARM_TIME) || (state_d == SET_CURRENT_TIME)) &&
                   !entry_ok_c;
   end

   // State, buffer and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= SHOW_TIME;
         ms_hr_q    <= '0;
         ls_hr_q    <= '0;
         ms_min_q   <= '0;
         ls_min_q   <= '0;
         cnt_q      <= '0;
         load_a_q   <= 1'b0;
         load_c_q   <= 1'b0;
         show_a_q   <= 1'b0;
         show_new_q <= 1'b0;
         err_q      <= 1'b0;
`ifdef KEYPAD_FULL_ENTRY_EN
         dcnt_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         ms_hr_q    <= ms_hr_d;
         ls_hr_q    <= ls_hr_d;
         ms_min_q   <= ms_min_d;
         ls_min_q   <= ls_min_d;
         cnt_q      <= cnt_d;
         load_a_q   <= load_a_d;
         load_c_q   <= load_c_d;
         show_a_q   <= show_a_d;
         show_new_q <= show_new_d;
         err_q      <= err_d;
`ifdef KEYPAD_FULL_ENTRY_EN
         dcnt_q     <= dcnt_d;
`endif
      end
   end

   assign new_ms_hr     = ms_hr_q;
   assign new_ls_hr     = ls_hr_q;
   assign new_ms_min    = ms_min_q;
   assign new_ls_min    = ls_min_q;
   assign load_new_a    = load_a_q;
   assign load_new_c    = load_c_q;
   assign show_a        = show_a_q;
   assign show_new_time = show_new_q;
   assign entry_err     = err_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed key/button sequences; expected commit
// results are queued and checked by an independent strobe monitor.
module tb_keypad_entry_ctrl;

   localparam logic [3:0] NK = 4'd10;
   localparam logic [2:0] K_A = 3'b100;  // load_new_a
   localparam logic [2:0] K_C = 3'b010;  // load_new_c
   localparam logic [2:0] K_E = 3'b001;  // entry_err

   logic       clock = 1'b0;
   logic       reset;
   logic       one_second;
   logic [3:0] key;
   logic       alarm_button, time_button;
   logic [3:0] new_ms_hr, new_ls_hr, new_ms_min, new_ls_min;
   logic       load_new_a, load_new_c, show_a, show_new_time, entry_err;

   typedef struct packed {
      logic [2:0]  kind;
      logic [15:0] digits;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   keypad_entry_ctrl dut (
      .clock(clock), .reset(reset), .one_second(one_second), .key(key),
      .alarm_button(alarm_button), .time_button(time_button),
      .new_ms_hr(new_ms_hr), .new_ls_hr(new_ls_hr),
      .new_ms_min(new_ms_min), .new_ls_min(new_ls_min),
      .load_new_a(load_new_a), .load_new_c(load_new_c),
      .show_a(show_a), .show_new_time(show_new_time), .entry_err(entry_err)
   );

   always #5 clock = ~clock;

   function automatic logic [15:0] digits();
      return {new_ms_hr, new_ls_hr, new_ms_min, new_ls_min};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe/error pulse must match the next queued expectation.
   always @(negedge clock) begin
      if (reset && (load_new_a || load_new_c || entry_err)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'({load_new_a, load_new_c, entry_err}), 32'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("strobe_kind", 32'({load_new_a, load_new_c, entry_err}), 32'(e.kind));
            check("strobe_digits", 32'(digits()), 32'(e.digits));
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] d);
      key = d;
      repeat (3) tick();
      key = NK;
      tick();
   endtask

   task automatic press4(input logic [15:0] v);
      for (int i = 3; i >= 0; i--) press(v[i*4 +: 4]);
   endtask

   task automatic commit(input logic a, input logic c, input logic [2:0] kind,
                         input logic [15:0] d, input string name);
      exp_t e;
      e.kind   = kind;
      e.digits = d;
      exp_q.push_back(e);
      alarm_button = a;
      time_button  = c;
      tick();
      alarm_button = 1'b0;
      time_button  = 1'b0;
      tick();
      check({name, "_drained"}, 32'(exp_q.size()), 32'(0));
      check({name, "_cleared"}, 32'({digits(), show_new_time}), 32'(0));
   endtask

   task automatic pulse_sec();
      one_second = 1'b1;
      tick();
      one_second = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; one_second = 1'b0; key = NK;
      alarm_button = 1'b0; time_button = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", 32'({digits(), load_new_a, load_new_c, show_a, show_new_time, entry_err}), 32'(0));
      reset = 1'b1;
      tick();

      // Basic time commit.
      press4(16'h1123);
      check("buf_1123", 32'({digits(), show_new_time}), 32'({16'h1123, 1'b1}));
      commit(1'b0, 1'b1, K_C, 16'h1123, "time_1123");

      // Alarm commit, range rejections and boundary acceptances.
      press4(16'h1130);
      commit(1'b1, 1'b0, K_A, 16'h1130, "alarm_1130");
      press4(16'h2500);
      commit(1'b0, 1'b1, K_E, 16'h2500, "err_2500");
      press4(16'h2359);
      commit(1'b0, 1'b1, K_C, 16'h2359, "time_2359");
      press4(16'h2400);
      commit(1'b1, 1'b0, K_E, 16'h2400, "err_2400");
      press4(16'h0060);
      commit(1'b0, 1'b1, K_E, 16'h0060, "err_0060");
      press4(16'h1959);
      commit(1'b1, 1'b1, K_A, 16'h1959, "both_buttons");

      // Five-digit entry drops the oldest digit.
      press4(16'h9123);
      press(4'd4);
      commit(1'b0, 1'b1, K_C, 16'h1234, "shift_drop");

      // Timeout after ten seconds of inactivity.
      press(4'd4);
      repeat (9) pulse_sec();
      check("pre_timeout", 32'({digits(), show_new_time}), 32'({16'h0004, 1'b1}));
      pulse_sec();
      check("timeout", 32'({digits(), show_new_time}), 32'(0));
      time_button = 1'b1;
      tick();
      time_button = 1'b0;
      tick();
      check("idle_time_btn", 32'({load_new_c, show_new_time}), 32'(0));

      // Timeout wins over a key in the same cycle.
      press(4'd5);
      repeat (9) pulse_sec();
      one_second = 1'b1;
      key = 4'd6;
      tick();
      one_second = 1'b0;
      key = NK;
      check("timeout_vs_key", 32'({digits(), show_new_time}), 32'(0));
      tick();

      // Alarm display while the button is held.
      alarm_button = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("show_a_held", 32'(show_a), 32'(1));
      end
      alarm_button = 1'b0;
      tick();
      check("show_a_release", 32'({show_a, load_new_a, load_new_c}), 32'(0));

      // A held key is stored once.
      key = 4'd7;
      repeat (20) tick();
      key = NK;
      tick();
      check("held_key", 32'({digits(), show_new_time}), 32'({16'h0007, 1'b1}));

      // Asynchronous reset in the middle of an entry.
      press(4'd1);
      key = 4'd2;
      tick();
      tick();
      check("pre_reset_buf", 32'(digits()), 32'(16'h0712));
      #2 reset = 1'b0;
      #1;
      check("async_reset", 32'({digits(), load_new_a, load_new_c, show_a, show_new_time, entry_err}), 32'(0));
      key = NK;
      @(posedge clock);
      #1 reset = 1'b1;
      tick();

      // Partial entry.
      press(4'd4);
      press(4'd5);
`ifdef KEYPAD_FULL_ENTRY_EN
      commit(1'b0, 1'b1, K_E, 16'h0045, "partial");
`else
      commit(1'b0, 1'b1, K_C, 16'h0045, "partial");
`endif

      repeat (3) tick();
      check("final_queue", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
